// File: rtl/decode_stage.sv
// Purpose : ID stage - decodes one 16-bit instr, reads the 8x16 register file (with
//           writeback bypass) and registers operands + controls into the ID/EX latch.
// Latency : 1 cycle, instr presented before edge N appears on all outputs after edge N.
// Backpr. : stallOut (combinational) asks fetch to hold instr on a load-use hazard;
//           a bubble is loaded instead and the held instr decodes on a later edge.
// Ports   : clk, rst (sync, active-high) | instr/instrValid from fetch | flush kills decode
//           wbEn/wbReg/wbData writeback | readData1/2, instant, aluSrc, aluOp, regWrite,
//           memRead, memWrite, memToReg, branch, destReg, validOut to EX | stallOut to fetch
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instrValid,
  input  logic        flush,
  input  logic        wbEn,
  input  logic [2:0]  wbReg,
  input  logic [15:0] wbData,
  output logic [15:0] readData1,
  output logic [15:0] readData2,
  output logic [15:0] instant,
  output logic        aluSrc,
  output logic [2:0]  aluOp,
  output logic        regWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        memToReg,
  output logic        branch,
  output logic [2:0]  destReg,
  output logic        validOut,
  output logic        stallOut
);

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ANDI  = 4'h2;
  localparam logic [3:0] OP_ORI   = 4'h3;
  localparam logic [3:0] OP_LW    = 4'h4;
  localparam logic [3:0] OP_SW    = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;

  logic [3:0]  opcode;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [15:0] immExt;

  assign opcode = instr[15:12];
  assign rs     = instr[11:9];
  assign rt     = instr[8:6];
  // R-type funct lives in imm[3:0], so it rides through to EX inside instant.
  assign immExt = {{10{instr[5]}}, instr[5:0]};

  // Register file; entry 0 is never written so it always reads back 0.
  logic [15:0] regFile [8];
  logic        wbLive;
  logic [15:0] rsData;
  logic [15:0] rtData;

  assign wbLive = wbEn && (wbReg != 3'd0);

  // Same-cycle writeback is forwarded so decode never waits on the register file.
  always_comb begin
    rsData = regFile[rs];
    rtData = regFile[rt];
    if (wbLive && (wbReg == rs)) rsData = wbData;
    if (wbLive && (wbReg == rt)) rtData = wbData;
  end

  // Decode table
  logic       dRegWrite;
  logic       dMemRead;
  logic       dMemWrite;
  logic       dMemToReg;
  logic       dBranch;
  logic       dAluSrc;
  logic [2:0] dAluOp;
  logic [2:0] dDest;
  logic       usesRt;

  always_comb begin
    dRegWrite = 1'b0;
    dMemRead  = 1'b0;
    dMemWrite = 1'b0;
    dMemToReg = 1'b0;
    dBranch   = 1'b0;
    dAluSrc   = 1'b0;
    dAluOp    = 3'b000;
    dDest     = 3'd0;
    usesRt    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dAluOp    = 3'b010;
        dDest     = rs;
        dRegWrite = 1'b1;
        usesRt    = 1'b1;
      end
      OP_ADDI: begin
        dAluSrc   = 1'b1;
        dDest     = rt;
        dRegWrite = 1'b1;
      end
      OP_ANDI: begin
        dAluOp    = 3'b011;
        dAluSrc   = 1'b1;
        dDest     = rt;
        dRegWrite = 1'b1;
      end
      OP_ORI: begin
        dAluOp    = 3'b100;
        dAluSrc   = 1'b1;
        dDest     = rt;
        dRegWrite = 1'b1;
      end
      OP_LW: begin
        dAluSrc   = 1'b1;
        dDest     = rt;
        dRegWrite = 1'b1;
        dMemRead  = 1'b1;
        dMemToReg = 1'b1;
      end
      OP_SW: begin
        dAluSrc   = 1'b1;
        dMemWrite = 1'b1;
        usesRt    = 1'b1;
      end
      OP_BEQ: begin
        dAluOp    = 3'b001;
        dBranch   = 1'b1;
        usesRt    = 1'b1;
      end
      default: ;
    endcase
  end

  // Load-use: the load sitting in ID/EX cannot forward its data in time, so
  // any consumer of its destination waits one cycle. Flush overrides the stall.
  logic hazard;
  logic bubble;

  assign hazard   = validOut && memRead && (destReg != 3'd0) &&
                    ((destReg == rs) || (usesRt && (destReg == rt)));
  assign stallOut = instrValid && !flush && hazard;
  assign bubble   = flush || !instrValid || hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regFile[i] <= 16'h0000;
    end else if (wbLive) begin
      regFile[wbReg] <= wbData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      validOut  <= 1'b0;
      regWrite  <= 1'b0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      memToReg  <= 1'b0;
      branch    <= 1'b0;
      aluSrc    <= 1'b0;
      aluOp     <= 3'b000;
      destReg   <= 3'd0;
      readData1 <= 16'h0000;
      readData2 <= 16'h0000;
      instant   <= 16'h0000;
    end else begin
      validOut  <= 1'b1;
      regWrite  <= dRegWrite;
      memRead   <= dMemRead;
      memWrite  <= dMemWrite;
      memToReg  <= dMemToReg;
      branch    <= dBranch;
      aluSrc    <= dAluSrc;
      aluOp     <= dAluOp;
      destReg   <= dDest;
      readData1 <= rsData;
      readData2 <= rtData;
      instant   <= immExt;
    end
  end

endmodule
